// File: rtl/alu_pkg.sv
// Shared types for the ALU issue slice.
// Op encoding and datapath width.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SLT  = 2'b10,
    OP_SHL4 = 2'b11
  } op_e;

endpackage

// File: rtl/alu_issue_if.sv
// Handshake and ALU bus bundle for alu_issue.
// slave = issue block side, master = upstream/downstream/ALU side.
interface alu_issue_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  op_e               in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_fwd_a;

  op_e               alu_con;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_fwd_a,
    output in_ready,
    output alu_con, alu_a, alu_b,
    input  alu_result,
    output out_valid, out_data,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_fwd_a,
    input  in_ready,
    input  alu_con, alu_a, alu_b,
    output alu_result,
    input  out_valid, out_data,
    output out_ready
  );

endinterface

// File: rtl/alu_issue.sv
// Two-stage issue/result pipeline around an external ALU.
// Define ALU_ISSUE_FWD_EN to forward the last result onto operand A.
module alu_issue
  import alu_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);

  logic              s1_valid;
  op_e               s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;

  logic              s2_free;
  logic              accept;
  logic              advance;
  logic [DATA_W-1:0] opnd_a;

  assign s2_free      = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign advance      = s1_valid && s2_free;

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= bus.in_op;
      s1_a     <= bus.in_a;
      s1_b     <= bus.in_b;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (advance) begin
      s2_valid <= 1'b1;
      s2_data  <= bus.alu_result;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_FWD_EN
  logic              s1_fwd;
  logic [DATA_W-1:0] last_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_fwd      <= 1'b0;
      last_result <= '0;
    end else begin
      if (accept)  s1_fwd      <= bus.in_fwd_a;
      if (advance) last_result <= bus.alu_result;
    end
  end

  // Muxed at ALU-drive time so a dependent op right behind needs no bubble
  assign opnd_a = s1_fwd ? last_result : s1_a;
`else
  logic unused_fwd;
  assign unused_fwd = bus.in_fwd_a;
  assign opnd_a     = s1_a;
`endif

  always_comb begin
    bus.alu_con = OP_ADD;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    if (s1_valid) begin
      bus.alu_con = s1_op;
      bus.alu_a   = opnd_a;
      bus.alu_b   = s1_b;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural ALU
// and an in-order result scoreboard.
module tb_alu_issue;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  alu_issue_if bus();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int nout = 0;
  int model_last = 0;
  logic bp_rand = 1'b0;
  logic sdone;
  logic [7:0] exp_q[$];
  logic [7:0] got[$];

  // External ALU stand-in
  always_comb begin
    unique case (bus.alu_con)
      OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
      OP_SLT:  bus.alu_result =
        {7'd0, $signed({bus.alu_a[7], bus.alu_a}) <
               $signed({bus.alu_b[7], bus.alu_b})};
      default: bus.alu_result = {bus.alu_b[3:0], 4'h0};
    endcase
  end

  function automatic int ref_res(op_e op, int a, int b);
    int sa, sb;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      OP_ADD:  return (a + b) % 256;
      OP_SUB:  return (a - b + 256) % 256;
      OP_SLT:  return (sa < sb) ? 1 : 0;
      default: return (b * 16) % 256;
    endcase
  endfunction

  function automatic void push_exp(op_e op, int a, int b, bit fwd);
    int ea, r;
    ea = a;
`ifdef ALU_ISSUE_FWD_EN
    if (fwd) ea = model_last;
`endif
    r = ref_res(op, ea, b);
    model_last = r;
    exp_q.push_back(r[7:0]);
  endfunction

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      nout++;
      got.push_back(bus.out_data);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_out: got %0h expected none",
                 bus.out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (e !== bus.out_data) begin
          miscompares++;
          $display("FAIL out_data: got %0h expected %0h",
                   bus.out_data, e);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(op_e op, logic [7:0] a, logic [7:0] b,
                      logic fwd);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_fwd_a = fwd;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_exp(op, int'(a), int'(b), fwd);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  typedef struct {
    string      name;
    op_e        op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[6];
  int base;

  initial begin
    tbl[0] = '{"add_05_03",  OP_ADD,  8'h05, 8'h03, 8'h08};
    tbl[1] = '{"sub_03_05",  OP_SUB,  8'h03, 8'h05, 8'hFE};
    tbl[2] = '{"slt_80_01",  OP_SLT,  8'h80, 8'h01, 8'h01};
    tbl[3] = '{"slt_01_80",  OP_SLT,  8'h01, 8'h80, 8'h00};
    tbl[4] = '{"shl4_0f",    OP_SHL4, 8'h77, 8'h0F, 8'hF0};
    tbl[5] = '{"add_wrap",   OP_ADD,  8'hFF, 8'h01, 8'h00};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = OP_ADD;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_fwd_a = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data, 0);
    chk("rst_alu_bus",
        {bus.alu_con, bus.alu_a, bus.alu_b}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      send(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
      @(negedge clk);
      chk({tbl[i].name, "_early"}, bus.out_valid, 0);
      @(negedge clk);
      chk(tbl[i].name, {bus.out_valid, bus.out_data},
          {1'b1, tbl[i].exp});
    end

    // Backpressure: four ops while downstream stalls
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    base  = nout;
    sdone = 1'b0;
    fork
      begin
        send(OP_ADD,  8'h01, 8'h01, 1'b0);
        send(OP_SUB,  8'h09, 8'h02, 1'b0);
        send(OP_SLT,  8'hFF, 8'h00, 1'b0);
        send(OP_SHL4, 8'h00, 8'h3C, 1'b0);
        sdone = 1'b1;
      end
    join_none
    repeat (3) @(negedge clk);
    chk("bp_in_ready",  bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_data",      bus.out_data, 8'h02);
    @(negedge clk);
    chk("bp_hold_ready", bus.in_ready, 0);
    chk("bp_hold_data",  bus.out_data, 8'h02);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 100 && !sdone; n++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_sender_done", sdone, 1);
    drain("bp_drain");
    chk("bp_count", nout - base, 4);
    if (got.size() >= 4) begin
      chk("bp_ord0", got[got.size()-4], 8'h02);
      chk("bp_ord1", got[got.size()-3], 8'h07);
      chk("bp_ord2", got[got.size()-2], 8'h01);
      chk("bp_ord3", got[got.size()-1], 8'hC0);
    end else begin
      chk("bp_got_size", got.size(), 4);
    end

    // Dependent pair
    @(posedge clk);
    #1;
    send(OP_ADD, 8'h10, 8'h20, 1'b0);
    send(OP_ADD, 8'h55, 8'h01, 1'b1);
    drain("fwd_drain");
    chk("fwd_first", got[got.size()-2], 8'h30);
`ifdef ALU_ISSUE_FWD_EN
    chk("fwd_second", got[got.size()-1], 8'h31);
`else
    chk("fwd_second", got[got.size()-1], 8'h56);
`endif

    // Reset with both stages full
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h02, 1'b0);
    send(OP_ADD, 8'h03, 8'h04, 1'b0);
    chk("pre_rst_valid", bus.out_valid, 1);
    chk("pre_rst_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_ready", bus.in_ready, 1);
    chk("rst_mid_data",  bus.out_data, 0);
    chk("rst_mid_alu_a", bus.alu_a, 0);
    exp_q.delete();
    model_last = 0;
    base = nout;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_stale", nout - base, 0);

    // Randomized traffic with random backpressure
    base = nout;
    bp_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send(op_e'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    end
    bp_rand = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain("rand_drain");
    chk("rand_count", nout - base, 200);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port in_valid, input, 1 bit: upstream offers an operation.
REQ-004 The block SHALL have port in_ready, output, 1 bit: block accepts the operation this cycle.
REQ-005 The block SHALL have port in_op, input, 2 bits: 00 add, 01 sub, 10 signed set-less-than, 11 B shift-left-4.
REQ-006 The block SHALL have port in_a, input, 8 bits: operand A.
REQ-007 The block SHALL have port in_b, input, 8 bits: operand B.
REQ-008 The block SHALL have port in_fwd_a, input, 1 bit: replace A with the previous result (forwarding build only).
REQ-009 The block SHALL have ports alu_con (2 bits), alu_a (8 bits) and alu_b (8 bits), all outputs, driving the datapath ALU.
REQ-010 The block SHALL have port alu_result, input, 8 bits: combinational ALU result.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a result is held.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream takes the result.
REQ-013 The block SHALL have port out_data, output, 8 bits: registered result.

Function
REQ-014 The block SHALL be a two-stage pipeline: S1 is the issue register (op, a, b, fwd, valid) and S2 is the result register (out_data, out_valid).
REQ-015 A transfer SHALL occur on a rising edge when valid and ready are both high; in_ready SHALL equal !s1_valid || s2_free, where s2_free = !out_valid || out_ready.
REQ-016 While s1_valid is high, alu_con, alu_a and alu_b SHALL come from S1; while s1_valid is low they SHALL be driven to zero.
REQ-017 When s1_valid && s2_free, S2 SHALL capture alu_result on that edge, out_valid SHALL go high, and S1 SHALL empty unless a new op is accepted on the same edge.
REQ-018 An op accepted at edge N SHALL appear on out_data with out_valid high after edge N+1 when there is no backpressure (latency 2 edges); sustained throughput SHALL be 1 op per cycle.
REQ-019 While out_valid && !out_ready, out_data and S1 contents SHALL hold unchanged and no op SHALL be lost or duplicated.
REQ-020 Simultaneous in-accept, S1-to-S2 advance and out-transfer in one cycle SHALL all take effect.
REQ-021 Register last_result SHALL load alu_result on every S1-to-S2 capture and SHALL otherwise hold its value.
REQ-022 The block SHALL present operands unmodified to the ALU; all arithmetic (8-bit wrap on add/sub, 9-bit sign-extended compare for SLT, B<<4 for op 11) SHALL be performed by the ALU.

Reset
REQ-023 On rst_n low, s1_valid, out_valid, out_data, last_result and all S1 fields SHALL clear to 0 immediately; in_ready SHALL then read 1.
REQ-024 Reset asserted mid-operation SHALL discard in-flight ops with no output emitted after release.

Configuration
REQ-025 With ALU_ISSUE_FWD_EN defined, an op with in_fwd_a=1 SHALL drive alu_a = last_result while in S1, evaluated at the time S1 drives the ALU, so back-to-back dependent ops need no bubble.
REQ-026 Without ALU_ISSUE_FWD_EN, in_fwd_a SHALL be ignored, last_result SHALL not be implemented, and alu_a SHALL always come from the captured in_a.

Structure
REQ-027 Package alu_pkg SHALL hold the 2-bit op enum (OP_ADD, OP_SUB, OP_SLT, OP_SHL4) and the constant DATA_W = 8.
REQ-028 The block SHALL be a single module with no sub-module; the ALU remains external.

Verification
REQ-029 The bench SHALL check: ADD a=05 b=03 -> out_data=08, 2 edges after accept.
REQ-030 The bench SHALL check: SUB a=03 b=05 -> FE; SLT a=80 b=01 -> 01; SLT a=01 b=80 -> 00; SHL4 b=0F -> F0.
REQ-031 The bench SHALL check: back-to-back 4 ops with out_ready held low for 3 cycles -> in_ready low after S1 fills, and results delivered in order with none dropped or repeated.
REQ-032 The bench SHALL check, with ALU_ISSUE_FWD_EN: ADD 10+20, then ADD fwd_a=1 b=01 on the next cycle -> outputs 30 then 31; without the macro, the second op yields in_a+01.
REQ-033 The bench SHALL check: rst_n pulsed low while out_valid=1 and S1 full -> out_valid=0 and in_ready=1 immediately, with no stale output after release.
